// File: rtl/serial_deser_rx.sv
// serial_deser_rx: start/data(LSB first)/[parity]/stop deserializer with valid/ready output.
// Optional even-parity bit enabled by defining PARITY_EN. Rev 1.0
`default_nettype none

module serial_deser_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sdi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
`ifdef PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun;
  logic [DATA_W:0]   w_cat;
  logic [DATA_W-1:0] w_shift_next;
  logic              w_par_ok;
  logic              w_slot_free;

  // Data arrives LSB first, so shift in from the top; after DATA_W bits bit 0 is the first one.
  assign w_cat        = {sdi, r_shift};
  assign w_shift_next = w_cat[DATA_W:1];
  assign w_slot_free  = ~r_valid | dout_ready;

`ifdef PARITY_EN
  logic r_par;
  logic r_parity_err;
  assign w_par_ok   = ~(^{r_shift, r_par});
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_valid && dout_ready) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!sdi) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end
        end
        S_DATA: begin
          r_shift <= w_shift_next;
          if (r_cnt == C_LAST) begin
`ifdef PARITY_EN
            r_state <= S_PARITY;
`else
            r_state <= S_STOP;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`ifdef PARITY_EN
        S_PARITY: begin
          r_par   <= sdi;
          r_state <= S_STOP;
        end
`endif
        S_STOP: begin
          r_state <= S_IDLE;
          if (!sdi) begin
            r_frame_err <= 1'b1;
          end else if (!w_par_ok) begin
`ifdef PARITY_EN
            r_parity_err <= 1'b1;
`endif
          end else if (w_slot_free) begin
            r_dout  <= r_shift;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_deser_rx.sv
// tb_serial_deser_rx: frame-level reference model with per-cycle compare plus literal checks.
// Rev 1.0
`default_nettype none

module tb_serial_deser_rx;

  localparam int DATA_W = 8;
  localparam int EV_GOOD = 0;
  localparam int EV_FE   = 1;
  localparam int EV_PE   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              sdi = 1'b1;
  logic              dout_ready = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_mode = 1;
  bit chk_en = 1'b0;

  // Stop-bit event posted by the driver, consumed by the model on the sampling edge.
  bit                ev_on = 1'b0;
  int                ev_kind = 0;
  logic [DATA_W-1:0] ev_word = '0;

  logic [DATA_W-1:0] m_dout  = '0;
  logic              m_valid = 1'b0;
  logic              m_fe    = 1'b0;
  logic              m_pe    = 1'b0;
  logic              m_ov    = 1'b0;

  serial_deser_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sdi        (sdi),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       dout_ready = 1'b0;
      1:       dout_ready = 1'b1;
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_dout <= '0; m_valid <= 1'b0; m_fe <= 1'b0; m_pe <= 1'b0; m_ov <= 1'b0;
    end else begin
      m_fe <= ev_on && (ev_kind == EV_FE);
      m_pe <= ev_on && (ev_kind == EV_PE);
      m_ov <= ev_on && (ev_kind == EV_GOOD) && m_valid && !dout_ready;
      if (ev_on && ev_kind == EV_GOOD && (!m_valid || dout_ready)) begin
        m_valid <= 1'b1;
        m_dout  <= ev_word;
      end else if (m_valid && dout_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model.dout_valid", 32'(dout_valid), 32'(m_valid));
      check("model.dout", 32'(dout), 32'(m_dout));
      check("model.frame_err", 32'(frame_err), 32'(m_fe));
      check("model.parity_err", 32'(parity_err), 32'(m_pe));
      check("model.overrun", 32'(overrun), 32'(m_ov));
    end
  end

  task automatic drive(input logic b, input bit ev, input int kind, input logic [DATA_W-1:0] w);
    @(posedge clk);
    #1;
    sdi     = b;
    ev_on   = ev;
    ev_kind = kind;
    ev_word = w;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w, input logic stop_b,
                            input bit par_flip, input int gap);
    int kind;
    logic p;
    for (int i = 0; i < gap; i++) drive(1'b1, 1'b0, 0, '0);
    drive(1'b0, 1'b0, 0, '0);
    for (int i = 0; i < DATA_W; i++) drive(w[i], 1'b0, 0, '0);
    p = (^w) ^ par_flip;
`ifdef PARITY_EN
    drive(p, 1'b0, 0, '0);
`endif
    if (!stop_b) kind = EV_FE;
`ifdef PARITY_EN
    else if ((^w) ^ p) kind = EV_PE;
`endif
    else kind = EV_GOOD;
    drive(stop_b, 1'b1, kind, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with sdi toggling.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      sdi = 1'(i & 1);
      if (i == 1) chk_en = 1'b1;
    end
    @(negedge clk);
    check("reset.dout_valid", 32'(dout_valid), 32'd0);
    check("reset.dout", 32'(dout), 32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;
    sdi = 1'b1;
    reset = 1'b1;
    idle(10);
    @(negedge clk);
    check("idle.dout_valid", 32'(dout_valid), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(1);
    @(negedge clk);
    check("a5.dout_valid", 32'(dout_valid), 32'd1);
    check("a5.dout", 32'(dout), 32'hA5);
    @(negedge clk);
    check("a5.valid_drop", 32'(dout_valid), 32'd0);

    send_frame(8'h3C, 1'b0, 1'b0, 2);
    idle(1);
    @(negedge clk);
    check("3c.frame_err", 32'(frame_err), 32'd1);
    check("3c.dout_valid", 32'(dout_valid), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1);
    idle(1);
    @(negedge clk);
    check("81.dout", 32'(dout), 32'h81);
    check("81.dout_valid", 32'(dout_valid), 32'd1);

    ready_mode = 0;
    idle(3);
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0);
    idle(1);
    @(negedge clk);
    check("ovr.overrun", 32'(overrun), 32'd1);
    check("ovr.dout", 32'(dout), 32'h11);
    check("ovr.dout_valid", 32'(dout_valid), 32'd1);
    ready_mode = 1;
    idle(3);
    @(negedge clk);
    check("ovr.accept", 32'(dout_valid), 32'd0);

`ifdef PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1);
    idle(1);
    @(negedge clk);
    check("par.dout", 32'(dout), 32'h07);
    send_frame(8'h07, 1'b1, 1'b1, 2);
    idle(1);
    @(negedge clk);
    check("par.parity_err", 32'(parity_err), 32'd1);
    check("par.dout_valid", 32'(dout_valid), 32'd0);
`endif

    // Pending word plus a partial frame, then asynchronous reset at data bit 4.
    ready_mode = 0;
    idle(2);
    send_frame(8'h33, 1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0, '0);
    drive(1'b0, 1'b0, 0, '0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 0, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst.dout_valid", 32'(dout_valid), 32'd0);
    check("rst.dout", 32'(dout), 32'd0);
    idle(2);
    reset = 1'b1;
    ready_mode = 1;
    send_frame(8'h5A, 1'b1, 1'b0, 2);
    idle(1);
    @(negedge clk);
    check("5a.dout", 32'(dout), 32'h5A);
    check("5a.dout_valid", 32'(dout_valid), 32'd1);

    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      logic [DATA_W-1:0] w;
      logic sb;
      bit pf;
      w  = DATA_W'($urandom);
      sb = ($urandom_range(0, 9) != 0);
      pf = ($urandom_range(0, 7) == 0);
      send_frame(w, sb, pf, int'($urandom_range(0, 3)));
    end
    idle(5);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
